// File: rtl/hazard_ctrl_r1.sv
// Pipeline hazard controller: N-source forwarding, load-use / branch-in-ID stalls, flushes, mul/div busy.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_r1 #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FWD_STAGES     = 2,
  parameter int FWD_SEL_WIDTH  = 3,
  parameter int MULDIV_CYCLES  = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [REG_ADDR_WIDTH-1:0]            id_rs,
  input  logic [REG_ADDR_WIDTH-1:0]            id_rt,
  input  logic                                 id_uses_rs,
  input  logic                                 id_uses_rt,
  input  logic                                 id_branch,
  input  logic                                 id_muldiv,
  input  logic                                 id_reads_hilo,
  input  logic                                 branchTaken,
  input  logic                                 jump,
  input  logic [REG_ADDR_WIDTH-1:0]            ex_rs,
  input  logic [REG_ADDR_WIDTH-1:0]            ex_rt,
  input  logic [REG_ADDR_WIDTH-1:0]            ex_regToWrite,
  input  logic                                 ex_regWrite,
  input  logic                                 ex_memRead,
  input  logic [FWD_STAGES*REG_ADDR_WIDTH-1:0] fwd_regToWrite,
  input  logic [FWD_STAGES-1:0]                fwd_regWrite,
  input  logic                                 fwd_memRead,
  output logic [FWD_SEL_WIDTH-1:0]             forwardA,
  output logic [FWD_SEL_WIDTH-1:0]             forwardB,
  output logic [FWD_SEL_WIDTH-1:0]             id_forwardA,
  output logic [FWD_SEL_WIDTH-1:0]             id_forwardB,
  output logic                                 pc_en_n,
  output logic                                 if_id_en_n,
  output logic                                 id_ex_bubble,
  output logic                                 if_id_flush,
  output logic                                 redirect,
  output logic                                 muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]                 stall_cycles,
  output logic [CNT_WIDTH-1:0]                 flush_count,
  output logic [CNT_WIDTH-1:0]                 muldiv_stall_cycles
`endif
);

  localparam int MD_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic {RUN, HOLD1} state_t;

  state_t              state;
  logic                reset_active;
  logic [MD_W-1:0]     md_cnt;
  logic                stall;
  logic                load_use;
  logic                br_alu;
  logic                br_mem;
  logic                md_stall;
  logic [FWD_STAGES-1:0] id_valid;

  function automatic logic src_match(input logic [REG_ADDR_WIDTH-1:0] dst,
                                     input logic [REG_ADDR_WIDTH-1:0] rs,
                                     input logic [REG_ADDR_WIDTH-1:0] rt,
                                     input logic urs, input logic urt);
    return (urs && (rs == dst)) || (urt && (rt == dst));
  endfunction

  // Walk from the oldest stage down so the lowest matching index is the last write.
  function automatic logic [FWD_SEL_WIDTH-1:0] fwd_sel(
      input logic [REG_ADDR_WIDTH-1:0]            src,
      input logic [FWD_STAGES-1:0]                valid,
      input logic [FWD_STAGES*REG_ADDR_WIDTH-1:0] dsts);
    logic [FWD_SEL_WIDTH-1:0] sel;
    sel = '0;
    if (src != '0) begin
      for (int unsigned k = FWD_STAGES; k > 0; k--) begin
        if (valid[k-1] && (dsts[(k-1)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == src))
          sel = FWD_SEL_WIDTH'(k);
      end
    end
    return sel;
  endfunction

  always_comb begin
    id_valid = fwd_regWrite;
    if (fwd_memRead) id_valid[0] = 1'b0;

    load_use = ex_memRead && ex_regWrite && (ex_regToWrite != '0) &&
               src_match(ex_regToWrite, id_rs, id_rt, id_uses_rs, id_uses_rt);
    br_alu   = id_branch && ex_regWrite && !ex_memRead &&
               src_match(ex_regToWrite, id_rs, id_rt, id_uses_rs, id_uses_rt);
    br_mem   = id_branch && fwd_memRead && fwd_regWrite[0] &&
               src_match(fwd_regToWrite[REG_ADDR_WIDTH-1:0], id_rs, id_rt, id_uses_rs, id_uses_rt);
    md_stall = !reset_active && muldiv_busy && (id_muldiv || id_reads_hilo);
    stall    = !reset_active &&
               (load_use || br_alu || br_mem || md_stall || (state == HOLD1));
  end

  assign muldiv_busy = (md_cnt != '0);

  // While the reset flag is up every output is held at its reset value.
  always_comb begin
    forwardA     = '0;
    forwardB     = '0;
    id_forwardA  = '0;
    id_forwardB  = '0;
    pc_en_n      = 1'b0;
    if_id_en_n   = 1'b0;
    id_ex_bubble = 1'b1;
    if_id_flush  = 1'b0;
    redirect     = 1'b0;
    if (!reset_active) begin
      forwardA    = fwd_sel(ex_rs, fwd_regWrite, fwd_regToWrite);
      forwardB    = fwd_sel(ex_rt, fwd_regWrite, fwd_regToWrite);
      id_forwardA = fwd_sel(id_rs, id_valid, fwd_regToWrite);
      id_forwardB = fwd_sel(id_rt, id_valid, fwd_regToWrite);
      if (stall) begin
        pc_en_n      = 1'b1;
        if_id_en_n   = 1'b1;
        id_ex_bubble = 1'b1;
      end else begin
        id_ex_bubble = 1'b0;
        redirect     = branchTaken || jump;
        if_id_flush  = branchTaken || jump;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      reset_active <= 1'b1;
      state        <= RUN;
      md_cnt       <= '0;
    end else begin
      reset_active <= 1'b0;
      case (state)
        RUN:     if (!reset_active && id_branch && load_use) state <= HOLD1;
        HOLD1:   state <= RUN;
        default: state <= RUN;
      endcase
      if (md_cnt != '0)
        md_cnt <= md_cnt - MD_W'(1);
      else if (!reset_active && id_muldiv && !stall)
        md_cnt <= MD_W'(MULDIV_CYCLES - 1);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles        <= '0;
      flush_count         <= '0;
      muldiv_stall_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if (if_id_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_WIDTH'(1);
      if (md_stall && (muldiv_stall_cycles != '1))
        muldiv_stall_cycles <= muldiv_stall_cycles + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_r1.sv
// Directed bench for hazard_ctrl_r1 (FWD_STAGES=3, MULDIV_CYCLES=4, CNT_WIDTH=4).
// Counter checks are compiled when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl_r1;
  localparam int W  = 5;
  localparam int NS = 3;
  localparam int SW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  id_rs, id_rt, ex_rs, ex_rt, ex_regToWrite;
  logic          id_uses_rs, id_uses_rt, id_branch, id_muldiv, id_reads_hilo;
  logic          branchTaken, jump, ex_regWrite, ex_memRead, fwd_memRead;
  logic [NS*W-1:0] fwd_regToWrite;
  logic [NS-1:0] fwd_regWrite;
  logic [SW-1:0] forwardA, forwardB, id_forwardA, id_forwardB;
  logic          pc_en_n, if_id_en_n, id_ex_bubble, if_id_flush, redirect, muldiv_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_count, muldiv_stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  hazard_ctrl_r1 #(
    .REG_ADDR_WIDTH(W), .FWD_STAGES(NS), .FWD_SEL_WIDTH(SW),
    .MULDIV_CYCLES(4), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_muldiv(id_muldiv), .id_reads_hilo(id_reads_hilo),
    .branchTaken(branchTaken), .jump(jump),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_regToWrite(ex_regToWrite),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .fwd_regToWrite(fwd_regToWrite), .fwd_regWrite(fwd_regWrite), .fwd_memRead(fwd_memRead),
    .forwardA(forwardA), .forwardB(forwardB),
    .id_forwardA(id_forwardA), .id_forwardB(id_forwardB),
    .pc_en_n(pc_en_n), .if_id_en_n(if_id_en_n), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .redirect(redirect), .muldiv_busy(muldiv_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .muldiv_stall_cycles(muldiv_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0; id_branch = 0;
    id_muldiv = 0; id_reads_hilo = 0; branchTaken = 0; jump = 0;
    ex_rs = '0; ex_rt = '0; ex_regToWrite = '0; ex_regWrite = 0; ex_memRead = 0;
    fwd_regToWrite = '0; fwd_regWrite = '0; fwd_memRead = 0;
  endtask

  task automatic rand_inputs();
    id_rs = W'($urandom); id_rt = W'($urandom); id_uses_rs = 1'($urandom);
    id_uses_rt = 1'($urandom); id_branch = 1'($urandom); id_muldiv = 1'($urandom);
    id_reads_hilo = 1'($urandom); branchTaken = 1'($urandom); jump = 1'($urandom);
    ex_rs = W'($urandom); ex_rt = W'($urandom); ex_regToWrite = W'($urandom);
    ex_regWrite = 1'($urandom); ex_memRead = 1'($urandom);
    fwd_regToWrite = (NS*W)'($urandom); fwd_regWrite = NS'($urandom);
    fwd_memRead = 1'($urandom);
  endtask

  task automatic ex_load(input logic [W-1:0] dst);
    ex_memRead = 1; ex_regWrite = 1; ex_regToWrite = dst;
  endtask

  initial begin
    // Reset with random inputs
    idle();
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step();
      chk("rst_bubble", id_ex_bubble, 1);
      chk("rst_outs", {forwardA, forwardB, id_forwardA, id_forwardB, pc_en_n,
                       if_id_en_n, if_id_flush, redirect, muldiv_busy}, 0);
    end
    idle();
    #1;
    rst = 1;
    step();
    chk("release_bubble", id_ex_bubble, 0);

    // Forwarding priority
    ex_rs = 5; fwd_regToWrite = {5'd5, 5'd7, 5'd5}; fwd_regWrite = 3'b101; #1;
    chk("fwdA_lowest", forwardA, 1);
    fwd_regWrite = 3'b100; #1;
    chk("fwdA_stage2", forwardA, 3);
    ex_rt = 7; fwd_regWrite = 3'b111; #1;
    chk("fwdB_stage1", forwardB, 2);
    ex_rs = 0; fwd_regToWrite = {5'd0, 5'd0, 5'd0}; #1;
    chk("fwdA_r0", forwardA, 0);
    id_rs = 5; fwd_regToWrite = {5'd5, 5'd7, 5'd5}; fwd_regWrite = 3'b101; fwd_memRead = 1; #1;
    chk("idfwdA_load_excl", id_forwardA, 3);
    fwd_memRead = 0; #1;
    chk("idfwdA_mem", id_forwardA, 1);
    id_rt = 7; fwd_regWrite = 3'b111; #1;
    chk("idfwdB_stage1", id_forwardB, 2);

    // Load-use: one stall cycle
    idle(); step();
    ex_load(8); id_rs = 8; id_uses_rs = 1; #1;
    chk("lu_pc_en_n", pc_en_n, 1);
    chk("lu_ifid_en_n", if_id_en_n, 1);
    chk("lu_bubble", id_ex_bubble, 1);
    step();
    ex_memRead = 0; ex_regWrite = 0; ex_regToWrite = 0;
    fwd_memRead = 1; fwd_regToWrite = {5'd0, 5'd0, 5'd8}; fwd_regWrite = 3'b001; #1;
    chk("lu_release_pc", pc_en_n, 0);
    chk("lu_release_bubble", id_ex_bubble, 0);
    idle(); step();
    ex_load(8); id_rs = 9; id_uses_rs = 1; #1;
    chk("lu_nomatch", pc_en_n, 0);

    // Branch after load: two stalls, then redirect + flush
    idle(); step();
    ex_load(4); id_branch = 1; id_rs = 4; id_uses_rs = 1; branchTaken = 1; #1;
    chk("bl_stall1", pc_en_n, 1);
    chk("bl_redirect1", redirect, 0);
    chk("bl_flush1", if_id_flush, 0);
    step();
    ex_memRead = 0; ex_regWrite = 0; ex_regToWrite = 0;
    fwd_memRead = 1; fwd_regToWrite = {5'd0, 5'd0, 5'd4}; fwd_regWrite = 3'b001; #1;
    chk("bl_stall2", pc_en_n, 1);
    chk("bl_redirect2", redirect, 0);
    step();
    fwd_memRead = 0; fwd_regToWrite = {5'd0, 5'd4, 5'd0}; fwd_regWrite = 3'b010; #1;
    chk("bl_go_pc", pc_en_n, 0);
    chk("bl_redirect", redirect, 1);
    chk("bl_flush", if_id_flush, 1);
    chk("bl_idfwd", id_forwardA, 2);
    step();
    idle(); #1;
    chk("bl_flush_off", if_id_flush, 0);

    // HOLD1 alone keeps the stall when the MEM stage shows nothing
    idle(); step();
    ex_load(4); id_branch = 1; id_rs = 4; id_uses_rs = 1; branchTaken = 1;
    step();
    ex_memRead = 0; ex_regWrite = 0; ex_regToWrite = 0; #1;
    chk("hold1_stall", pc_en_n, 1);
    step();
    chk("hold1_done", pc_en_n, 0);
    chk("hold1_redirect", redirect, 1);

    // Branch on ALU result in EX
    idle(); step();
    ex_regWrite = 1; ex_regToWrite = 6; id_branch = 1; id_rt = 6; id_uses_rt = 1;
    branchTaken = 1; #1;
    chk("br_alu_stall", pc_en_n, 1);
    chk("br_alu_noredir", redirect, 0);
    id_uses_rt = 0; #1;
    chk("br_alu_unused", redirect, 1);

    // Branch on load sitting in MEM
    idle(); step();
    id_branch = 1; id_rs = 3; id_uses_rs = 1;
    fwd_memRead = 1; fwd_regWrite = 3'b001; fwd_regToWrite = {5'd0, 5'd0, 5'd3}; #1;
    chk("br_mem_stall", pc_en_n, 1);

    // Jump with no hazard
    idle(); step();
    jump = 1; #1;
    chk("jump_redirect", redirect, 1);
    chk("jump_flush", if_id_flush, 1);
    chk("jump_bubble", id_ex_bubble, 0);

    // Mul/div: issue then mfhi stalls for 3 cycles
    idle(); step();
    id_muldiv = 1; #1;
    chk("md_issue_nostall", pc_en_n, 0);
    step();
    id_muldiv = 0; id_reads_hilo = 1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("md_busy", muldiv_busy, 1);
      chk("md_stall", pc_en_n, 1);
      step();
    end
    chk("md_idle", muldiv_busy, 0);
    chk("md_release", pc_en_n, 0);

    // Back-to-back issue: second starts after busy falls
    idle(); id_muldiv = 1; #1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("md2_stall", pc_en_n, 1);
      step();
    end
    chk("md2_free", muldiv_busy, 0);
    chk("md2_nostall", pc_en_n, 0);
    step();
    chk("md2_restart", muldiv_busy, 1);

    // Reset while busy
    idle(); step();
    chk("md_mid", muldiv_busy, 1);
    rst = 0;
    step();
    chk("md_rst_busy", muldiv_busy, 0);
    rst = 1;
    step();
    chk("md_rst_release", id_ex_bubble, 0);

`ifdef HAZARD_PERF_CNT_EN
    chk("cnt_clear", stall_cycles, 0);
    ex_load(8); id_rs = 8; id_uses_rs = 1;
    repeat (3) step();
    chk("cnt_stall3", stall_cycles, 3);
    repeat (17) step();
    chk("cnt_stall_sat", stall_cycles, 15);
    idle(); jump = 1;
    repeat (2) step();
    chk("cnt_flush", flush_count, 2);
    idle(); id_muldiv = 1;
    step();
    id_muldiv = 0; id_reads_hilo = 1;
    repeat (3) step();
    chk("cnt_mdstall", muldiv_stall_cycles, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_r1.md
Name: hazard_ctrl_r1

Overview:
- Parametrised pipeline hazard controller for the 5-stage MIPS core.
- Generalises the two-source forwarding unit to FWD_STAGES forwarding sources.
- Adds load-use and branch-in-ID stalls, control-flow flushes, and a multi-cycle mul/div busy tracker.
- Sits beside the pipeline registers and drives their en_n / bubble inputs, the PC enable, and the EX and ID forwarding muxes.

Parameters:
REG_ADDR_WIDTH, 5, register address width
FWD_STAGES, 2, number of forwarding sources downstream of EX (index 0 = MEM, 1 = WB, ...); range 1..6
FWD_SEL_WIDTH, 3, forward select width; must satisfy 2^FWD_SEL_WIDTH > FWD_STAGES
MULDIV_CYCLES, 32, mul/div unit latency in cycles (>=2)
CNT_WIDTH, 16, width of the stall/flush counters (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
id_rs, id_rt  in  REG_ADDR_WIDTH each  ID source registers
id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
id_branch  in  1  ID instruction is beq/bne/jr (operands consumed in ID)
id_muldiv, id_reads_hilo  in  1 each  ID issues mul/div; ID reads HI/LO
branchTaken, jump  in  1 each  raw control-flow redirect from ID
ex_rs, ex_rt  in  REG_ADDR_WIDTH each  EX source registers
ex_regToWrite  in  REG_ADDR_WIDTH  EX destination
ex_regWrite, ex_memRead  in  1 each  EX control
fwd_regToWrite  in  FWD_STAGES*REG_ADDR_WIDTH  packed destinations (slice k = stage k)
fwd_regWrite  in  FWD_STAGES  write enables, bit k = stage k
fwd_memRead  in  1  MEM stage (stage 0) is a load
forwardA, forwardB  out  FWD_SEL_WIDTH each  EX operand select (0 = regfile, k+1 = stage k)
id_forwardA, id_forwardB  out  FWD_SEL_WIDTH each  ID comparator select, same encoding
pc_en_n, if_id_en_n  out  1 each  hold PC / IF-ID register
id_ex_bubble  out  1  zero control bits into ID/EX
if_id_flush  out  1  squash instruction in IF/ID
redirect  out  1  gated branchTaken|jump for the PC mux
muldiv_busy  out  1  mul/div unit occupied

Behaviour:
- Reset (rst==0 at clk edge): FSM=RUN, muldiv counter=0. Outputs: forwards 0, pc_en_n 0, if_id_en_n 0, if_id_flush 0, redirect 0, muldiv_busy 0, id_ex_bubble 1.
- Forward select: combinational from current inputs.
  - Compare ex_rs (resp. ex_rt) against every fwd slice with fwd_regWrite set.
  - Lowest matching index wins (newest data); output index+1, else 0.
  - Register 0 never forwards.
- ID forwards use the same rule on id_rs / id_rt. Stage 0 is excluded when fwd_memRead=1.
- Stall sources (combinational, OR'd into the signal stall):
  a) Load-use: ex_memRead & ex_regWrite & ex_regToWrite!=0 & matches a used ID source.
  b) Branch-ALU: id_branch & ex_regWrite & !ex_memRead & EX destination matches a used source.
  c) Branch-load-MEM: id_branch & fwd_memRead & fwd_regWrite[0] & slice-0 destination matches a used source.
  d) Mul/div: muldiv_busy & (id_muldiv | id_reads_hilo).
- FSM RUN/HOLD1:
  - RUN -> HOLD1 when id_branch meets the load-use condition (a). The load needs two cycles before the comparator can use it.
  - HOLD1 forces stall for one more cycle, then returns to RUN.
  - Reset in HOLD1 -> RUN.
- stall==1: pc_en_n=1, if_id_en_n=1, id_ex_bubble=1, redirect=0, if_id_flush=0. Stall wins over redirect because branch operands are not yet valid.
- stall==0: redirect = branchTaken|jump; if_id_flush = redirect (1 cycle, no delay slot); id_ex_bubble=0.
- Mul/div counter:
  - Loads MULDIV_CYCLES-1 when id_muldiv & !stall & !muldiv_busy.
  - Decrements each cycle while nonzero; muldiv_busy = (counter!=0).
  - An issue attempt while busy is stalled by (d) and starts on the cycle after busy falls.
  - Flush does not cancel a running operation.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cycles, flush_count, muldiv_stall_cycles (CNT_WIDTH each).
  - Synchronous clear on reset.
  - Each increments on cycles with stall, if_id_flush, or stall source (d) respectively.
  - Saturate at all-ones.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> id_ex_bubble=1, all other outputs 0; release -> bubble 0 next cycle.
- Forwarding priority: FWD_STAGES=3, ex_rs=5, slices 0 and 2 write r5 -> forwardA=1; clear bit 0 -> forwardA=3; ex_rs=0 with a slice writing r0 -> forwardA=0.
- Load-use: EX lw r8, ID add uses r8 -> exactly 1 stall cycle (pc_en_n=1, bubble=1); ID uses only r9 -> no stall.
- Branch after load: EX lw r4, ID beq r4 with branchTaken=1 -> 2 stall cycles with redirect=0, then redirect=1 and if_id_flush=1 for 1 cycle.
- Mul/div: MULDIV_CYCLES=4, issue mult, next ID mfhi -> busy for 3 cycles, ID stalled 3 cycles; reset mid-busy -> busy=0 next cycle.
- Counters (macro on, CNT_WIDTH=4): force 20 stall cycles -> stall_cycles=15 saturated.
